// File: rtl/config_flit_tx_if.sv
// Host/node signal bundle for config_flit_tx: command request, flit transmit
// with credit return, flit receive, and read response.
interface config_flit_tx_if #(
  parameter int FW  = 59,
  parameter int XW  = 4,
  parameter int YW  = 4,
  parameter int ATW = 3,
  parameter int CAW = 15,
  parameter int CDW = 21
);
  logic           req_valid;
  logic           req_ready;
  logic           req_rw;
  logic [XW-1:0]  req_dst_x;
  logic [YW-1:0]  req_dst_y;
  logic [ATW-1:0] req_atype;
  logic [CAW-1:0] req_addr;
  logic [CDW-1:0] req_wdata;

  logic           tx_we;
  logic [FW-1:0]  tx_wdata;
  logic           tx_credit;

  logic           rx_we;
  logic [FW-1:0]  rx_wdata;

  logic           rsp_valid;
  logic [CDW-1:0] rsp_rdata;
  logic           rsp_timeout;

  // Host bridge / node environment side.
  modport master (
    output req_valid, req_rw, req_dst_x, req_dst_y, req_atype, req_addr, req_wdata,
    input  req_ready,
    input  tx_we, tx_wdata,
    output tx_credit,
    output rx_we, rx_wdata,
    input  rsp_valid, rsp_rdata, rsp_timeout
  );

  // Flit initiator side.
  modport slave (
    input  req_valid, req_rw, req_dst_x, req_dst_y, req_atype, req_addr, req_wdata,
    output req_ready,
    output tx_we, tx_wdata,
    input  tx_credit,
    input  rx_we, rx_wdata,
    output rsp_valid, rsp_rdata, rsp_timeout
  );
endinterface

// File: rtl/config_flit_tx.sv
// Host-side configuration-flit initiator: packs write/read commands into flits
// under credit flow control and matches read responses. Optional macro
// CFG_RD_TIMEOUT_EN enables a read-response timeout.
module config_flit_tx #(
  parameter int FW      = 59,
  parameter int FTW     = 3,
  parameter int XW      = 4,
  parameter int YW      = 4,
  parameter int ATW     = 3,
  parameter int CAW     = 15,
  parameter int CDW     = 21,
  parameter int CREDITS = 4,
  parameter int TOW     = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [XW-1:0] src_x,
  input  logic [YW-1:0] src_y,
  config_flit_tx_if.slave bus,
  output logic          busy
);

  localparam int CW = $clog2(CREDITS + 1);
  localparam logic [CW-1:0] CRED_MAX = CW'(CREDITS);

  localparam logic [FTW-1:0] FT_WR      = FTW'(1);
  localparam logic [FTW-1:0] FT_RD      = FTW'(2);
  localparam logic [FTW-1:0] FT_RD_RESP = FTW'(3);

  typedef struct packed {
    logic [FTW-1:0] ftype;
    logic [XW-1:0]  dst_x;
    logic [YW-1:0]  dst_y;
    logic [XW-1:0]  src_x;
    logic [YW-1:0]  src_y;
    logic           rsvd;
    logic [ATW-1:0] atype;
    logic [CAW-1:0] addr;
    logic [CDW-1:0] data;
  } flit_t;

  typedef enum logic [1:0] {IDLE, SEND, WAIT_RESP} state_t;

  state_t         state, state_nxt;
  logic [CW-1:0]  credits, credits_nxt;
  logic           accept;
  logic           send;
  logic           match;
  logic           timeout_hit;

  logic           lat_rw;
  logic [XW-1:0]  lat_dst_x;
  logic [YW-1:0]  lat_dst_y;
  logic [CAW-1:0] lat_addr;

  flit_t          tx_flit;
  flit_t          rx_flit;

  assign tx_flit = '{
    ftype: bus.req_rw ? FT_WR : FT_RD,
    dst_x: bus.req_dst_x,
    dst_y: bus.req_dst_y,
    src_x: src_x,
    src_y: src_y,
    rsvd:  1'b0,
    atype: bus.req_atype,
    addr:  bus.req_addr,
    data:  bus.req_rw ? bus.req_wdata : '0
  };

  assign rx_flit = bus.rx_wdata;

  // A response answers our read only if it comes from the node we addressed.
  assign match = (state == WAIT_RESP) && bus.rx_we
              && (rx_flit.ftype == FT_RD_RESP)
              && (rx_flit.src_x == lat_dst_x)
              && (rx_flit.src_y == lat_dst_y)
              && (rx_flit.addr  == lat_addr);

  logic unused_rx;
  assign unused_rx = ^{rx_flit.dst_x, rx_flit.dst_y, rx_flit.rsvd, rx_flit.atype};

  assign send = (state == SEND);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    state_nxt     = state;
    bus.req_ready = 1'b0;
    accept        = 1'b0;
    case (state)
      IDLE: begin
        bus.req_ready = (credits != '0) && !rst;
        accept        = bus.req_valid && (credits != '0) && !rst;
        if (accept) state_nxt = SEND;
      end
      SEND:      state_nxt = lat_rw ? IDLE : WAIT_RESP;
      WAIT_RESP: if (match || timeout_hit) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  // A send and a returned credit in the same cycle cancel out.
  always_comb begin
    credits_nxt = credits;
    if (send && !bus.tx_credit)
      credits_nxt = credits - 1'b1;
    else if (!send && bus.tx_credit && (credits != CRED_MAX))
      credits_nxt = credits + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
      credits   <= CRED_MAX;
      lat_rw    <= 1'b0;
      lat_dst_x <= '0;
      lat_dst_y <= '0;
      lat_addr  <= '0;
    end else begin
      credits <= credits_nxt;
      if (accept) begin
        lat_rw    <= bus.req_rw;
        lat_dst_x <= bus.req_dst_x;
        lat_dst_y <= bus.req_dst_y;
        lat_addr  <= bus.req_addr;
      end
    end
  end

  // The flit is registered at accept so tx_we coincides with the SEND state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.tx_we       <= 1'b0;
      bus.tx_wdata    <= '0;
      bus.rsp_valid   <= 1'b0;
      bus.rsp_rdata   <= '0;
      bus.rsp_timeout <= 1'b0;
    end else begin
      bus.tx_we     <= accept;
      bus.rsp_valid <= 1'b0;
      if (accept) bus.tx_wdata <= tx_flit;
      if (match) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_rdata   <= rx_flit.data;
        bus.rsp_timeout <= 1'b0;
      end else if (timeout_hit) begin
        bus.rsp_valid   <= 1'b1;
        bus.rsp_rdata   <= '0;
        bus.rsp_timeout <= 1'b1;
      end
    end
  end

`ifdef CFG_RD_TIMEOUT_EN
  logic [TOW-1:0] to_cnt;
  localparam logic [TOW-1:0] TO_PRELAST = {{(TOW-1){1'b1}}, 1'b0};

  // The read expires on the edge where the counter steps onto all-ones.
  assign timeout_hit = (state == WAIT_RESP) && (to_cnt == TO_PRELAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                     to_cnt <= '0;
    else if (send)               to_cnt <= '0;
    else if (state == WAIT_RESP) to_cnt <= to_cnt + 1'b1;
  end
`else
  logic [TOW-1:0] unused_tow;
  assign unused_tow  = '0;
  assign timeout_hit = 1'b0;
`endif

  assign busy = (state != IDLE) || (credits != CRED_MAX);

endmodule

// File: tb/tb_config_flit_tx.sv
// Directed self-checking bench for config_flit_tx: packing, read round trip,
// credit handling, response filtering, optional timeout and mid-read reset.
module tb_config_flit_tx;

`ifdef CFG_RD_TIMEOUT_EN
  localparam int TOW_P = 4;
`else
  localparam int TOW_P = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] src_x;
  logic [3:0] src_y;
  logic       busy;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  config_flit_tx_if bus ();

  config_flit_tx #(.TOW(TOW_P)) dut (
    .clk  (clk),
    .rst  (rst),
    .src_x(src_x),
    .src_y(src_y),
    .bus  (bus.slave),
    .busy (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic rw, input logic [3:0] dx, input logic [3:0] dy,
                         input logic [2:0] at, input logic [14:0] addr, input logic [20:0] wd);
    bus.req_valid = 1'b1;
    bus.req_rw    = rw;
    bus.req_dst_x = dx;
    bus.req_dst_y = dy;
    bus.req_atype = at;
    bus.req_addr  = addr;
    bus.req_wdata = wd;
  endtask

  task automatic pulse_credit();
    bus.tx_credit = 1'b1;
    step();
    bus.tx_credit = 1'b0;
  endtask

  // Issue a read and advance until the design is waiting for the response.
  task automatic start_read(input logic [14:0] addr);
    set_cmd(1'b0, 4'd3, 4'd5, 3'd0, addr, 21'h12345);
    step();
    bus.req_valid = 1'b0;
    step();
  endtask

  function automatic logic [58:0] resp_flit(input logic [2:0] ft, input logic [3:0] sx,
                                            input logic [3:0] sy, input logic [14:0] addr,
                                            input logic [20:0] data);
    return {ft, 4'd1, 4'd2, sx, sy, 1'b0, 3'd0, addr, data};
  endfunction

  task automatic inject(input logic [58:0] f);
    bus.rx_we    = 1'b1;
    bus.rx_wdata = f;
    step();
    bus.rx_we    = 1'b0;
  endtask

  initial begin
    int n;
    int found;

    src_x = 4'd1;
    src_y = 4'd2;
    bus.req_valid = 1'b0;
    bus.req_rw    = 1'b0;
    bus.req_dst_x = '0;
    bus.req_dst_y = '0;
    bus.req_atype = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    bus.tx_credit = 1'b0;
    bus.rx_we     = 1'b0;
    bus.rx_wdata  = '0;

    // Reset state
    step();
    step();
    check("rst_tx_we",       64'(bus.tx_we), 64'd0);
    check("rst_tx_wdata",    64'(bus.tx_wdata), 64'd0);
    check("rst_rsp_valid",   64'(bus.rsp_valid), 64'd0);
    check("rst_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rst_rsp_rdata",   64'(bus.rsp_rdata), 64'd0);
    check("rst_req_ready",   64'(bus.req_ready), 64'd0);
    check("rst_credits",     64'(dut.credits), 64'd4);
    rst = 1'b0;
    step();
    check("idle_req_ready",  64'(bus.req_ready), 64'd1);
    check("idle_busy",       64'(busy), 64'd0);

    // Write packing
    set_cmd(1'b1, 4'd3, 4'd5, 3'd2, 15'h0010, 21'h00ABC);
    step();
    bus.req_valid = 1'b0;
    check("wr_tx_we",     64'(bus.tx_we), 64'd1);
    check("wr_tx_wdata",  64'(bus.tx_wdata),
          64'({3'b001, 4'd3, 4'd5, 4'd1, 4'd2, 1'b0, 3'd2, 15'h0010, 21'h00ABC}));
    check("wr_send_ready", 64'(bus.req_ready), 64'd0);
    step();
    check("wr_tx_we_off", 64'(bus.tx_we), 64'd0);
    check("wr_credits",   64'(dut.credits), 64'd3);
    check("wr_idle_ready", 64'(bus.req_ready), 64'd1);
    check("wr_busy",      64'(busy), 64'd1);
    pulse_credit();
    check("wr_credit_back", 64'(dut.credits), 64'd4);
    check("wr_busy_clear",  64'(busy), 64'd0);

    // Read round trip: the RD flit carries zero data even though wdata is set
    set_cmd(1'b0, 4'd3, 4'd5, 3'd0, 15'h0020, 21'h12345);
    step();
    bus.req_valid = 1'b0;
    check("rd_tx_we",    64'(bus.tx_we), 64'd1);
    check("rd_tx_wdata", 64'(bus.tx_wdata),
          64'({3'b010, 4'd3, 4'd5, 4'd1, 4'd2, 1'b0, 3'd0, 15'h0020, 21'h0}));
    step();
    check("rd_wait_ready", 64'(bus.req_ready), 64'd0);
    pulse_credit();
    inject(resp_flit(3'b011, 4'd3, 4'd5, 15'h0020, 21'h1F00F));
    check("rd_rsp_valid",   64'(bus.rsp_valid), 64'd1);
    check("rd_rsp_rdata",   64'(bus.rsp_rdata), 64'h1F00F);
    check("rd_rsp_timeout", 64'(bus.rsp_timeout), 64'd0);
    check("rd_back_idle",   64'(bus.req_ready), 64'd1);
    step();
    check("rd_rsp_pulse",   64'(bus.rsp_valid), 64'd0);
    check("rd_rdata_held",  64'(bus.rsp_rdata), 64'h1F00F);

    // Credit return in the same cycle as a send leaves the count unchanged
    set_cmd(1'b1, 4'd6, 4'd7, 3'd1, 15'h0100, 21'h00001);
    step();
    bus.req_valid = 1'b0;
    pulse_credit();
    check("same_cycle_credits", 64'(dut.credits), 64'd4);

    // Credit exhaustion with req_valid held
    set_cmd(1'b1, 4'd2, 4'd2, 3'd0, 15'h0004, 21'h0000F);
    n = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (bus.tx_we) n++;
    end
    check("exh_flits",   64'(n), 64'd4);
    check("exh_ready",   64'(bus.req_ready), 64'd0);
    check("exh_credits", 64'(dut.credits), 64'd0);
    pulse_credit();
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      if (bus.tx_we) n++;
    end
    bus.req_valid = 1'b0;
    check("exh_one_more", 64'(n), 64'd1);
    for (int i = 0; i < 6; i++) pulse_credit();
    check("exh_saturate", 64'(dut.credits), 64'd4);
    check("exh_busy",     64'(busy), 64'd0);

    // Responses outside WAIT_RESP are ignored
    inject(resp_flit(3'b011, 4'd3, 4'd5, 15'h0020, 21'h00777));
    check("idle_rx_ignored", 64'(bus.rsp_valid), 64'd0);
    check("idle_rx_rdata",   64'(bus.rsp_rdata), 64'h1F00F);

    // Mismatch filter
    start_read(15'h0020);
    inject(resp_flit(3'b011, 4'd3, 4'd5, 15'h0021, 21'h00111));
    check("mm_addr",  64'(bus.rsp_valid), 64'd0);
    inject(resp_flit(3'b001, 4'd3, 4'd5, 15'h0020, 21'h00222));
    check("mm_type",  64'(bus.rsp_valid), 64'd0);
    inject(resp_flit(3'b011, 4'd4, 4'd5, 15'h0020, 21'h00333));
    check("mm_src",   64'(bus.rsp_valid), 64'd0);
    check("mm_still_waiting", 64'(bus.req_ready), 64'd0);
    inject(resp_flit(3'b011, 4'd3, 4'd5, 15'h0020, 21'h00055));
    check("mm_good_valid", 64'(bus.rsp_valid), 64'd1);
    check("mm_good_rdata", 64'(bus.rsp_rdata), 64'h00055);
    pulse_credit();

`ifdef CFG_RD_TIMEOUT_EN
    // Read timeout: response expected 15 cycles after entering WAIT_RESP
    start_read(15'h0040);
    found = 0;
    for (int k = 1; k <= 20; k++) begin
      step();
      if (bus.rsp_valid) begin
        found = k;
        break;
      end
    end
    check("to_cycle",   64'(found), 64'd15);
    check("to_flag",    64'(bus.rsp_timeout), 64'd1);
    check("to_rdata",   64'(bus.rsp_rdata), 64'd0);
    check("to_ready",   64'(bus.req_ready), 64'd1);
    check("to_credits", 64'(dut.credits), 64'd3);
    set_cmd(1'b1, 4'd3, 4'd5, 3'd0, 15'h0008, 21'h00009);
    step();
    bus.req_valid = 1'b0;
    check("to_next_cmd", 64'(bus.tx_we), 64'd1);
    step();
    pulse_credit();
    pulse_credit();
`endif

    // Reset mid-read with one credit left
    for (int w = 0; w < 2; w++) begin
      set_cmd(1'b1, 4'd3, 4'd5, 3'd0, 15'h0001, 21'h00002);
      step();
      bus.req_valid = 1'b0;
      step();
    end
    start_read(15'h0030);
    check("mr_credits_before", 64'(dut.credits), 64'd1);
    rst = 1'b1;
    #1;
    check("mr_credits", 64'(dut.credits), 64'd4);
    check("mr_ready",   64'(bus.req_ready), 64'd0);
    check("mr_busy",    64'(busy), 64'd0);
    check("mr_rdata",   64'(bus.rsp_rdata), 64'd0);
    step();
    rst = 1'b0;
    step();
    check("mr_idle_ready", 64'(bus.req_ready), 64'd1);
    inject(resp_flit(3'b011, 4'd3, 4'd5, 15'h0030, 21'h0ABCD));
    check("mr_late_resp", 64'(bus.rsp_valid), 64'd0);
    check("mr_late_rdata", 64'(bus.rsp_rdata), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/config_flit_tx.md
Name: config_flit_tx

Overview:
- Host-side initiator for the node configuration protocol.
- Accepts register-level write/read commands and packs them into configuration flits, sending each write or read as one flit.
- Sends flits toward a node's spike-input config port using credit flow control.
- Receives read-response flits from the node's spike-output path and returns the read data to the host.
- Sits between the chip-level host bridge and the NoC injection point.

Parameters:
FW, 59, flit width
FTW, 3, flit type width
XW, 4, node x coordinate width
YW, 4, node y coordinate width
ATW, 3, config address-type width
CAW, 15, config address width
CDW, 21, config data width
CREDITS, 4, receiver buffer depth (initial credit count)
TOW, 10, read-timeout counter width

Ports:
clk  input  1  single clock
rst  input  1  asynchronous, active-high reset
src_x  input  XW  own x coordinate, static
src_y  input  YW  own y coordinate, static
req_valid  input  1  host command valid
req_ready  output  1  command accepted when req_valid & req_ready
req_rw  input  1  1=write, 0=read
req_dst_x  input  XW  target node x
req_dst_y  input  YW  target node y
req_atype  input  ATW  config address type
req_addr  input  CAW  config address
req_wdata  input  CDW  write data
tx_we  output  1  flit write strobe
tx_wdata  output  FW  outgoing flit
tx_credit  input  1  one-cycle pulse, one buffer slot freed
rx_we  input  1  incoming flit strobe
rx_wdata  input  FW  incoming flit
rsp_valid  output  1  one-cycle pulse, read finished
rsp_rdata  output  CDW  read data, held until next rsp_valid
rsp_timeout  output  1  qualifies rsp_valid; read timed out
busy  output  1  state != IDLE or credits < CREDITS

Behaviour:
- Flit layout (MSB to LSB, default positions):
  - [58:56] type
  - [55:52] dst_x
  - [51:48] dst_y
  - [47:44] src_x
  - [43:40] src_y
  - [39] 0
  - [38:36] atype
  - [35:21] addr
  - [20:0] data
- Flit types: 3'b001 WR, 3'b010 RD, 3'b011 RD_RESP. Every other type is dropped silently.
- For an RD flit the data field is 0.
- Reset values:
  - tx_we, rsp_valid, rsp_timeout = 0
  - tx_wdata, rsp_rdata = 0
  - credit counter = CREDITS
  - state = IDLE
  - req_ready = 0 while rst is asserted
- FSM states: IDLE, SEND, WAIT_RESP.
  - IDLE: req_ready = (credits != 0). On accept, latch the command and go to SEND.
  - SEND: drive tx_we = 1 with the packed flit for exactly one cycle and decrement credits.
    - Write: go to IDLE (posted write).
    - Read: go to WAIT_RESP and clear the timeout counter.
  - WAIT_RESP: req_ready = 0. The only flit that completes the read is RD_RESP with src field == latched dst and addr == latched addr.
    - On match: rsp_rdata = data field; rsp_valid = 1 with rsp_timeout = 0 on the next cycle; go to IDLE.
    - RD_RESP flits that do not match are dropped.
- Latency:
  - Accept to tx_we: exactly 1 cycle.
  - Matching rx_we to rsp_valid: 1 cycle.
- Credits:
  - A tx_credit pulse increments the counter; the counter saturates at CREDITS, and surplus pulses are ignored.
  - A credit return and a flit send in the same cycle leave the count unchanged.
  - With credits == 0, req_ready stays low and nothing is sent.
- Only one read is outstanding at a time. Writes may be sent back-to-back every 2 cycles (IDLE then SEND).
- rx_we outside WAIT_RESP is ignored.
- If rst asserts mid-operation, all state returns immediately to reset values, including credits = CREDITS.

Optional Feature:
CFG_RD_TIMEOUT_EN
- Defined: in WAIT_RESP a TOW-bit counter increments every cycle.
  - When it reaches all-ones with no match: rsp_valid = 1, rsp_timeout = 1, rsp_rdata = 0, go to IDLE.
  - The consumed credit is not restored.
  - A match in the same cycle as the terminal count wins: normal response, rsp_timeout = 0.
- Not defined: no counter, WAIT_RESP waits indefinitely, rsp_timeout is tied to 0.

Test Plan:
- Write packing: src (1,2); write dst (3,5), atype 3'd2, addr 15'h0010, wdata 21'h00ABC → one tx_we, tx_wdata = {3'b001,4'd3,4'd5,4'd1,4'd2,1'b0,3'd2,15'h0010,21'h00ABC}; credits 4→3; back in IDLE after 1 cycle.
- Read round trip: read dst (3,5), addr 15'h0020 → RD flit with data 0, req_ready low. Inject RD_RESP with src (3,5), addr 15'h0020, data 21'h1F00F → rsp_valid pulse 1 cycle later, rsp_rdata = 21'h1F00F, rsp_timeout = 0.
- Credit exhaustion: 4 writes with no tx_credit → 4 flits, then req_ready = 0 with req_valid held. One tx_credit pulse → exactly one more flit. 6 extra credit pulses → counter saturates at 4.
- Mismatch filter: during a read of addr 15'h0020, inject RD_RESP with addr 15'h0021, then a WR-type flit → no rsp_valid; a correct response afterwards completes normally.
- Timeout (macro defined, TOW=4): read with no response → rsp_valid & rsp_timeout, rsp_rdata = 0, at cycle 15 after entering WAIT_RESP. The next command is accepted.
- Reset mid-read: assert rst in WAIT_RESP with credits = 1 → credits = 4, state IDLE, outputs 0. A late RD_RESP is ignored.
